// File: rtl/eeprom_bank_ctrl.sv
// eeprom_bank_ctrl: serialised sequencer for a bank of four 8Kx8 EEPROMs.
// Define EEPROM_DATA_POLL_EN to end writes by bit-7 data polling.
module eeprom_bank_ctrl #(
   parameter int ADDR_W   = 13,
   parameter int RD_WAIT  = 4,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 3,
   parameter int WR_HOLD  = 1,
   parameter int WR_CYCLE = 10000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ee_a,
   output logic [31:0]       ee_io_o,
   input  logic [31:0]       ee_io_i,
   output logic              ee_io_oe,
   output logic              ee_ce_n,
   output logic              ee_oe_n,
   output logic              ee_we_n
);

   // Counters hold (cycles - 1); a zero parameter behaves like 1.
   localparam logic [31:0] LD_RD = (RD_WAIT  > 1) ? 32'(RD_WAIT  - 1) : 32'd0;
   localparam logic [31:0] LD_SU = (WR_SETUP > 1) ? 32'(WR_SETUP - 1) : 32'd0;
   localparam logic [31:0] LD_PL = (WR_PULSE > 1) ? 32'(WR_PULSE - 1) : 32'd0;
   localparam logic [31:0] LD_HD = (WR_HOLD  > 1) ? 32'(WR_HOLD  - 1) : 32'd0;
   localparam logic [31:0] LD_CY = (WR_CYCLE > 1) ? 32'(WR_CYCLE - 1) : 32'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ACC,
      S_RD_END,
      S_WR_SU,
      S_WR_PL,
      S_WR_HD,
`ifdef EEPROM_DATA_POLL_EN
      S_WR_POLL
`else
      S_WR_WT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              alive_q;
   logic              accept;
   logic              rd_last;

`ifdef EEPROM_DATA_POLL_EN
   logic [31:0] pcnt_q, pcnt_d;
   logic        gap_q, gap_d;
   logic        poll_hit;

   assign poll_hit = ({ee_io_i[31], ee_io_i[23], ee_io_i[15], ee_io_i[7]} ==
                      {wdata_q[31], wdata_q[23], wdata_q[15], wdata_q[7]});
`endif

   assign accept    = (state_q == S_IDLE) && alive_q && req_valid;
   assign rd_last   = (state_q == S_RD_ACC) && (cnt_q == '0);
   assign ee_a      = addr_q;
   assign ee_io_o   = wdata_q;
   assign rsp_rdata = rdata_q;

   // State and phase counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
`ifdef EEPROM_DATA_POLL_EN
         pcnt_q  <= '0;
         gap_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef EEPROM_DATA_POLL_EN
         pcnt_q  <= pcnt_d;
         gap_q   <= gap_d;
`endif
      end
   end

   // Request capture, read data sample and post-reset ready enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (rd_last) rdata_q <= ee_io_i;
      end
   end

   // Next state, counter reloads and pin decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
`ifdef EEPROM_DATA_POLL_EN
      pcnt_d    = pcnt_q;
      gap_d     = gap_q;
`endif
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      ee_io_oe  = 1'b0;
      ee_ce_n   = 1'b1;
      ee_oe_n   = 1'b1;
      ee_we_n   = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy      = 1'b0;
            req_ready = alive_q;
            if (accept) begin
               state_d = req_we ? S_WR_SU : S_RD_ACC;
               cnt_d   = req_we ? LD_SU : LD_RD;
            end
         end
         S_RD_ACC: begin
            ee_ce_n = 1'b0;
            ee_oe_n = 1'b0;
            if (cnt_q == '0) state_d = S_RD_END;
            else cnt_d = cnt_q - 32'd1;
         end
         S_RD_END: begin
            rsp_valid = 1'b1;
            state_d   = S_IDLE;
         end
         S_WR_SU: begin
            ee_ce_n  = 1'b0;
            ee_io_oe = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_WR_PL;
               cnt_d   = LD_PL;
            end else cnt_d = cnt_q - 32'd1;
         end
         S_WR_PL: begin
            ee_ce_n  = 1'b0;
            ee_io_oe = 1'b1;
            ee_we_n  = 1'b0;
            if (cnt_q == '0) begin
               state_d = S_WR_HD;
               cnt_d   = LD_HD;
            end else cnt_d = cnt_q - 32'd1;
         end
         S_WR_HD: begin
            ee_ce_n  = 1'b0;
            ee_io_oe = 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = LD_CY;
`ifdef EEPROM_DATA_POLL_EN
               state_d = S_WR_POLL;
               pcnt_d  = LD_RD;
               gap_d   = 1'b0;
`else
               state_d = S_WR_WT;
`endif
            end else cnt_d = cnt_q - 32'd1;
         end
`ifdef EEPROM_DATA_POLL_EN
         S_WR_POLL: begin
            ee_ce_n = gap_q;
            ee_oe_n = gap_q;
            cnt_d   = cnt_q - 32'd1;
            if (gap_q) begin
               gap_d  = 1'b0;
               pcnt_d = LD_RD;
            end else if (pcnt_q == '0) begin
               gap_d  = 1'b1;
            end else pcnt_d = pcnt_q - 32'd1;
            if (cnt_q == '0) state_d = S_IDLE;
            else if (!gap_q && pcnt_q == '0 && poll_hit) state_d = S_IDLE;
         end
`else
         S_WR_WT: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else cnt_d = cnt_q - 32'd1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_eeprom_bank_ctrl.sv
// tb_eeprom_bank_ctrl: directed checks of eeprom_bank_ctrl timing and data.
// Honours EEPROM_DATA_POLL_EN to exercise the polling write end.
module tb_eeprom_bank_ctrl;

   localparam int AW = 13;
   localparam int RW = 4;
`ifdef EEPROM_DATA_POLL_EN
   localparam int WRC = 100;
   localparam int WR_OCC = 1 + 3 + 1 + RW + 1;
`else
   localparam int WRC = 20;
   localparam int WR_OCC = 1 + 3 + 1 + WRC + 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          busy;
   logic [AW-1:0] ee_a;
   logic [31:0]   ee_io_o, ee_io_i;
   logic          ee_io_oe, ee_ce_n, ee_oe_n, ee_we_n;

   logic [31:0]   mem [0:8191] = '{default: 32'h0};
   logic [31:0]   sh  [0:15]   = '{default: 32'h0};
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_a = '0;
   logic [31:0]   pre_d = '0;
   int            reads = 0;
   int            inv_until = 0;
   int            viol = 0;
   int            errs = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   eeprom_bank_ctrl #(
      .ADDR_W(AW), .RD_WAIT(RW), .WR_SETUP(1), .WR_PULSE(3),
      .WR_HOLD(1), .WR_CYCLE(WRC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .ee_a(ee_a), .ee_io_o(ee_io_o), .ee_io_i(ee_io_i),
      .ee_io_oe(ee_io_oe), .ee_ce_n(ee_ce_n), .ee_oe_n(ee_oe_n),
      .ee_we_n(ee_we_n)
   );

   // Chip model: reads return memory, optionally with bit 7 of each byte flipped.
   assign ee_io_i = (!ee_ce_n && !ee_oe_n) ?
                    (mem[ee_a] ^ ((reads < inv_until) ? 32'h80808080 : 32'h0)) :
                    32'h0;

   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (!ee_we_n && !ee_ce_n) mem[ee_a] <= ee_io_o;
   end

   always @(posedge ee_oe_n) reads++;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (!ee_we_n && !ee_oe_n) viol++;
         if (ee_io_oe && !ee_oe_n) viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_a = a; pre_d = d;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic req(input logic we, input logic [AW-1:0] a,
                      input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      while (!req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic do_rd(input logic [AW-1:0] a, output logic [31:0] d,
                        output int lat, output int oe_cnt);
      req(1'b0, a, 32'h0);
      lat = 0; oe_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!ee_oe_n) oe_cnt++;
      end while (!rsp_valid && lat < 100);
      d = rsp_rdata;
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [31:0] d,
                        output int occ, output logic [7:0] pat,
                        output int bad);
      req(1'b1, a, d);
      occ = 0; pat = '0; bad = 0;
      do begin
         @(negedge clk);
         occ++;
         if (ee_io_oe) begin
            pat = {pat[6:0], ~ee_we_n};
            if (ee_a !== a || ee_io_o !== d) bad++;
         end
      end while (!req_ready && occ < 500);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  pat;
      int          lat, oe_cnt, occ, bad, n, acc, drift;
      logic        we;
      logic [3:0]  ri;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0;
      #2;
      chk("rst_ctl",
          32'({req_ready, rsp_valid, busy, ee_io_oe, ee_ce_n, ee_oe_n, ee_we_n}),
          32'b0000111);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_addr_data", 32'(ee_a) | ee_io_o, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      preload(13'h0123, 32'h6A09E667);
      preload(13'h0000, 32'h428A2F98);
      preload(13'h0001, 32'h71374491);

      do_rd(13'h0123, d, lat, oe_cnt);
      chk("rd_data", d, 32'h6A09E667);
      chk("rd_latency", 32'(lat), 32'(RW + 1));
      chk("rd_oe_cycles", 32'(oe_cnt), 32'(RW));

      do_wr(13'h1FFF, 32'hBB67AE85, occ, pat, bad);
      chk("wr_occupancy", 32'(occ), 32'(WR_OCC));
      chk("wr_we_pattern", 32'(pat), 32'b01110);
      chk("wr_addr_data_stable", 32'(bad), 32'd0);
      do_rd(13'h1FFF, d, lat, oe_cnt);
      chk("wr_readback", d, 32'hBB67AE85);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h0000;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 req_addr = 13'h0001;
      n = 0; acc = 0; drift = 0;
      do begin
         @(negedge clk);
         n++;
         if (req_ready) acc++;
         if (ee_a !== 13'h0000) drift++;
      end while (!rsp_valid && n < 50);
      chk("b2b_first_data", rsp_rdata, 32'h428A2F98);
      chk("b2b_ready_while_busy", 32'(acc), 32'd0);
      chk("b2b_addr_held", 32'(drift), 32'd0);
      @(negedge clk);
      chk("b2b_ready_gap", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      chk("b2b_second_data", rsp_rdata, 32'h71374491);
      chk("b2b_second_lat", 32'(n), 32'(RW + 1));

`ifdef EEPROM_DATA_POLL_EN
      inv_until = reads + 7;
      do_wr(13'h0055, 32'h80808080, occ, pat, bad);
      chk("poll_8th_read", 32'(occ), 32'(5 + 7 * (RW + 1) + RW + 1));
      inv_until = reads + 100000;
      do_wr(13'h0056, 32'h80808080, occ, pat, bad);
      chk("poll_timeout", 32'(occ), 32'(5 + WRC + 1));
      inv_until = 0;
`endif

      for (int i = 0; i < 1000; i++) begin
         we = 1'($urandom_range(0, 1));
         ri = 4'($urandom_range(0, 15));
         if (we) begin
            d = $urandom;
            do_wr(13'h0040 + 13'(ri), d, occ, pat, bad);
            sh[ri] = d;
         end else begin
            do_rd(13'h0040 + 13'(ri), d, lat, oe_cnt);
            chk("rand_rd", d, sh[ri]);
         end
      end
      chk("pin_invariants", 32'(viol), 32'd0);

      req(1'b1, 13'h0ABC, 32'h3C6EF372);
      n = 0;
      while (ee_we_n && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_pulse_seen", 32'(ee_we_n), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_pins",
          32'({ee_we_n, ee_ce_n, ee_io_oe, busy, ee_oe_n}), 32'b11001);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eeprom_bank_ctrl.md
Name: eeprom_bank_ctrl

Overview:
- Sequences a bank of four 8Kx8 parallel EEPROM chips. The chips share address and control lines and together form one 8K x 32-bit word store.
- Presents a single valid/ready request port to the datapath (SHA-256 constant/message store) and a one-cycle response strobe for reads.
- Generates every access timing: read access wait, write setup/pulse/hold, and the internal write-cycle wait.
- Sits between the core datapath and the board-level EEPROM pins; pin tristating is done by the top level from ee_io_oe.

Parameters:
- ADDR_W, 13, word address width (8K words).
- RD_WAIT, 4, clk cycles from OE_n/CE_n low to data sample (min 1).
- WR_SETUP, 1, cycles address/data stable before WE_n falls (min 1).
- WR_PULSE, 3, cycles WE_n held low (min 1).
- WR_HOLD, 1, cycles address/data held after WE_n rises (min 1).
- WR_CYCLE, 10000, cycles of internal programming time after WR_HOLD (min 1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  32  write data; byte0=[7:0] goes to chip 0 ... byte3=[31:24] to chip 3.
- rsp_valid  out  1  one-cycle strobe, read data valid.
- rsp_rdata  out  32  read data, held until the next read completes.
- busy  out  1  high in any non-IDLE state.
- ee_a  out  ADDR_W  shared chip address.
- ee_io_o  out  32  data driven to chips.
- ee_io_i  in  32  data from chips.
- ee_io_oe  out  1  1 = drive ee_io_o onto pins.
- ee_ce_n  out  1  shared chip enable, active low.
- ee_oe_n  out  1  shared output enable, active low.
- ee_we_n  out  1  shared write enable, active low.

Behaviour:
- Reset values (async, rst_n low): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, ee_a=0, ee_io_o=0, ee_io_oe=0, ee_ce_n=1, ee_oe_n=1, ee_we_n=1, all counters 0.
- Reset mid-operation aborts immediately and all pins go inactive at once; an aborted write leaves chip contents undefined.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready.
- On acceptance, ee_a, the write data and the op are captured into registers; request inputs are ignored until the controller returns to IDLE.
- ee_io_oe=1 only in WR_SETUP, WR_PULSE and WR_HOLD. ee_oe_n and ee_io_oe are never both active; ee_we_n and ee_oe_n are never both low.
- The bank is fully serialised: one request in flight, no overlap, no write buffering.
- IDLE -> RD_ACC (read) or WR_SU (write) on acceptance.
- RD_ACC: ee_ce_n=0, ee_oe_n=0 for RD_WAIT cycles. On the last cycle, sample ee_io_i into rsp_rdata, then go to RD_END.
- RD_END (1 cycle): ee_ce_n=1, ee_oe_n=1, rsp_valid=1, then go to IDLE.
- Read latency, acceptance edge to rsp_valid high: RD_WAIT+1 cycles. Back-to-back reads: one IDLE cycle between them.
- WR_SU: ee_ce_n=0, ee_io_oe=1, ee_we_n=1, for WR_SETUP cycles.
- WR_PL: ee_we_n=0 for WR_PULSE cycles.
- WR_HD: ee_we_n=1, ee_ce_n=0 and ee_io_oe=1 still, for WR_HOLD cycles.
- WR_WT: all chip controls inactive, ee_io_oe=0, for WR_CYCLE cycles, then go to IDLE. No rsp_valid for writes.
- Write occupancy, acceptance to req_ready high: WR_SETUP+WR_PULSE+WR_HOLD+WR_CYCLE+1 cycles.
- Counters load on state entry and count down to zero; a value of 0 is forbidden and is treated as 1.
- Address wrap: not applicable; the full ADDR_W range is valid.

Optional Feature:
- Macro: EEPROM_DATA_POLL_EN.
- Defined: WR_WT is replaced by WR_POLL. WR_POLL repeatedly performs an RD_WAIT-cycle read with 1 idle cycle between reads. It compares bit 7 of each byte of ee_io_i with bit 7 of the corresponding written byte (bits 7,15,23,31). When all four match, it returns to IDLE. A WR_CYCLE-cycle counter still bounds WR_POLL; on expiry it returns to IDLE anyway. No read response is produced.
- Undefined: fixed WR_CYCLE wait exactly as above.

Test Plan:
- Reset: assert rst_n=0 mid-WR_PL (ee_we_n=0) -> same cycle ee_we_n=1, ee_ce_n=1, ee_io_oe=0, busy=0; after release req_ready=1 on the first clk.
- Read: addr=0x0123, model returns 0x6A09E667 -> rsp_valid high exactly RD_WAIT+1=5 cycles after acceptance, rsp_rdata=0x6A09E667, ee_oe_n low for 4 cycles.
- Write: addr=0x1FFF, data=0xBB67AE85, WR_CYCLE=20 -> ee_we_n low exactly 3 cycles; ee_a/ee_io_o stable from 1 cycle before to 1 cycle after; req_ready returns after 26 cycles; a following read of 0x1FFF returns 0xBB67AE85.
- Back-to-back: req_valid held high with reads to 0x0000 and 0x0001 -> second accepted one cycle after the first rsp_valid; requests during busy are not accepted (req_ready=0).
- Invariant check over 1000 random ops: ee_we_n and ee_oe_n never both 0; ee_io_oe never 1 while ee_oe_n=0.
- EEPROM_DATA_POLL_EN: model inverts bit 7 for 7 reads after a write of 0x80808080 -> return to IDLE after the 8th poll read; with the model stuck, return after WR_CYCLE cycles.
